// File: rtl/sw_load_if.sv
// Search-window load bus: fetch-side beats in, buffer writes out.
// Also carries the load control and status strobes.
interface sw_load_if;
    logic        start;
    logic        mode;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic        sw_we;
    logic [8:0]  sw_addr_in;
    logic [31:0] sw_data_in;
    logic [8:0]  rd_base;
    logic        busy;
    logic        done;

    modport slave (
        input  start, mode, in_valid, in_data,
        output in_ready, sw_we, sw_addr_in, sw_data_in,
        output rd_base, busy, done
    );

    modport master (
        output start, mode, in_valid, in_data,
        input  in_ready, sw_we, sw_addr_in, sw_data_in,
        input  rd_base, busy, done
    );
endinterface

// File: rtl/sw_load_ctrl.sv
// Search-window buffer load controller: full loads and rotating
// column-slice loads into a circular word buffer.
module sw_load_ctrl #(
    parameter int NUM_WORDS = 88,
    parameter int ROT_WORDS = 22
) (
    input logic     clk,
    input logic     rst,
    sw_load_if.slave bus
);
    localparam logic [8:0] LAST_PTR = 9'(NUM_WORDS - 1);
    localparam logic [8:0] FULL_LEN = 9'(NUM_WORDS);
    localparam logic [8:0] ROT_LEN  = 9'(ROT_WORDS);

    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

    state_t      state;
    state_t      stateNext;
    logic [8:0]  wrPtr;
    logic [8:0]  wrPtrInc;
    logic [8:0]  beatCnt;
    logic [8:0]  loadLen;
    logic        weReg;
    logic [8:0]  addrReg;
    logic [31:0] dataReg;
    logic [8:0]  rdBaseReg;
    logic        startAcc;
    logic        accept;
    logic        lastBeat;

    assign startAcc = (state == IDLE) && bus.start;
    assign accept   = (state == LOAD) && bus.in_valid && !rst;
    assign lastBeat = accept && (beatCnt == loadLen - 9'd1);
    assign wrPtrInc = (wrPtr == LAST_PTR) ? 9'd0 : wrPtr + 9'd1;

    always_comb begin
        stateNext = state;
        unique case (state)
            IDLE:    if (bus.start) stateNext = LOAD;
            LOAD:    if (lastBeat) stateNext = DONE;
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            wrPtr     <= '0;
            beatCnt   <= '0;
            loadLen   <= '0;
            weReg     <= 1'b0;
            addrReg   <= '0;
            dataReg   <= '0;
            rdBaseReg <= '0;
        end else begin
            state <= stateNext;
            weReg <= accept;
            if (startAcc) begin
                loadLen <= bus.mode ? ROT_LEN : FULL_LEN;
                beatCnt <= '0;
                // rotate loads continue from where the last slice ended
                if (!bus.mode) wrPtr <= '0;
            end
            if (accept) begin
                addrReg <= wrPtr;
                dataReg <= bus.in_data;
                wrPtr   <= wrPtrInc;
                beatCnt <= beatCnt + 9'd1;
                if (lastBeat) rdBaseReg <= wrPtrInc;
            end
        end
    end

    // outputs are forced idle for the whole reset cycle
    assign bus.in_ready   = (state == LOAD) && !rst;
    assign bus.busy       = (state != IDLE) && !rst;
    assign bus.done       = (state == DONE) && !rst;
    assign bus.sw_we      = weReg && !rst;
    assign bus.sw_addr_in = rst ? 9'd0 : addrReg;
    assign bus.sw_data_in = rst ? 32'd0 : dataReg;
    assign bus.rd_base    = rst ? 9'd0 : rdBaseReg;
endmodule
